// File: rtl/ceres_param.sv
// Shared types and constants for the IO-memory RAM controller.
// Pure declarations; no latency. No handshake of its own.
package ceres_param;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int LINE_W = 128;
    localparam int STRB_W = 16;
    localparam int CNT_W  = 8;

    localparam int          DEF_RAM_DELAY = 16;
    localparam int          DEF_RAM_DEPTH = 8192;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] DEF_MASK_ADDR = 32'h000F_FFFF;

    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/iomem_ram_ctrl_if.sv
// Request/response bus plus RAM port of the IO-memory RAM controller.
// Wires only; no latency. Requester holds req_valid_i until res_valid_o.
interface iomem_ram_ctrl_if #(
    parameter int AW = 13
) ();

    logic                          req_valid_i;
    logic [31:0]                   req_addr_i;
    logic [ceres_param::LINE_W-1:0] req_data_i;
    logic [ceres_param::STRB_W-1:0] req_rw_i;

    logic                          res_valid_o;
    logic                          res_ready_o;
    logic [ceres_param::LINE_W-1:0] res_data_o;

    logic [AW-1:0]                 ram_addr_o;
    logic [ceres_param::LINE_W-1:0] ram_wdata_o;
    logic [ceres_param::STRB_W-1:0] ram_wr_en_o;
    logic                          ram_rd_en_o;
    logic [ceres_param::LINE_W-1:0] ram_rdata_i;

    modport slave (
        input  req_valid_i, req_addr_i, req_data_i, req_rw_i, ram_rdata_i,
        output res_valid_o, res_ready_o, res_data_o,
        output ram_addr_o, ram_wdata_o, ram_wr_en_o, ram_rd_en_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_data_i, req_rw_i, ram_rdata_i,
        input  res_valid_o, res_ready_o, res_data_o,
        input  ram_addr_o, ram_wdata_o, ram_wr_en_o, ram_rd_en_o
    );

endinterface

// File: rtl/iomem_ram_ctrl.sv
// Single-outstanding RAM window controller: one 128-bit line per request.
// Latency RAM_DELAY cycles from accept to the one-cycle response pulse.
// Backpressure: res_ready_o only in IDLE; misses are never accepted.
module iomem_ram_ctrl
    import ceres_param::*;
#(
    parameter int          RAM_DELAY = DEF_RAM_DELAY,
    parameter int          RAM_DEPTH = DEF_RAM_DEPTH,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] MASK_ADDR = DEF_MASK_ADDR
) (
    input  logic             clk_i,
    input  logic             rst_i,
    iomem_ram_ctrl_if.slave  bus
);

    localparam int               AW       = $clog2(RAM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_DELAY - 2);

    state_t              r_state;
    logic [AW-1:0]       r_addr;
    logic [LINE_W-1:0]   r_data;
    logic [STRB_W-1:0]   r_rw;
    logic [STRB_W-1:0]   r_wr_en;
    logic                r_rd_en;
    logic                r_cap;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_line;

    logic                w_hit;
    logic                w_is_rd;
    logic [LINE_W-1:0]   w_cap_line;

    assign w_hit      = bus.req_valid_i && addr_hit(bus.req_addr_i, BASE_ADDR, MASK_ADDR);
    assign w_is_rd    = (r_rw == '0);
    assign w_cap_line = w_is_rd ? bus.ram_rdata_i : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_rw    <= '0;
            r_wr_en <= '0;
            r_rd_en <= 1'b0;
            r_cap   <= 1'b0;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            r_rd_en <= 1'b0;
            r_wr_en <= '0;
            // RAM data arrives the cycle after ISSUE, whatever state that is
            r_cap   <= (r_state == ST_ISSUE);
            if (r_cap) begin
                r_line <= w_cap_line;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_addr  <= bus.req_addr_i[AW+3:4];
                        r_data  <= bus.req_data_i;
                        r_rw    <= bus.req_rw_i;
                        r_rd_en <= (bus.req_rw_i == '0);
                        r_wr_en <= bus.req_rw_i;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= (RAM_DELAY == 2) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.res_ready_o = (r_state == ST_IDLE);
    assign bus.res_valid_o = (r_state == ST_RESP);
    // With the shortest delay the capture cycle is RESP itself, so forward it
    assign bus.res_data_o  = (r_state == ST_RESP && r_cap) ? w_cap_line : r_line;
    assign bus.ram_addr_o  = r_addr;
    assign bus.ram_wdata_o = r_data;
    assign bus.ram_wr_en_o = r_wr_en;
    assign bus.ram_rd_en_o = r_rd_en;

endmodule

// File: tb/tb_iomem_ram_ctrl.sv
// Bench for iomem_ram_ctrl: directed vector table, random traffic against a line-level memory model,
// plus back-to-back, mid-transaction reset and minimum-delay sequences.
module tb_iomem_ram_ctrl;
    import ceres_param::*;

    localparam int          DEPTH = 8192;
    localparam int          AW    = 13;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] MASK  = 32'h000F_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    iomem_ram_ctrl_if #(.AW(AW)) bus ();
    iomem_ram_ctrl_if #(.AW(AW)) bus2 ();

    iomem_ram_ctrl #(.RAM_DELAY(16), .RAM_DEPTH(DEPTH), .BASE_ADDR(BASE), .MASK_ADDR(MASK))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    iomem_ram_ctrl #(.RAM_DELAY(2), .RAM_DEPTH(DEPTH), .BASE_ADDR(BASE), .MASK_ADDR(MASK))
        dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));

    int n_chk = 0;
    int n_fail = 0;

    logic [127:0] mem [DEPTH];
    logic [127:0] model_mem [DEPTH];
    logic [127:0] rdata0;
    logic [127:0] rdata2;
    assign bus.ram_rdata_i  = rdata0;
    assign bus2.ram_rdata_i = rdata2;

    function automatic logic [127:0] init_line(input int i);
        if (i == 1) return {16{8'hA5}};
        return {4{32'hC0DE_0000 | 32'(i)}};
    endfunction

    // Synchronous RAM: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_line(i);
        end else begin
            if (bus.ram_rd_en_o) rdata0 <= mem[bus.ram_addr_o];
            for (int b = 0; b < 16; b++)
                if (bus.ram_wr_en_o[b]) mem[bus.ram_addr_o][b*8 +: 8] <= bus.ram_wdata_o[b*8 +: 8];
            if (bus2.ram_rd_en_o) rdata2 <= mem[bus2.ram_addr_o];
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return (a & ~MASK) == BASE;
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a & MASK) >> 4) % DEPTH;
    endfunction

    task automatic model_txn(input logic [31:0] a, input logic [15:0] rw,
                             input logic [127:0] d, output logic [127:0] exp_res);
        int idx;
        idx = model_idx(a);
        if (rw == 16'h0) begin
            exp_res = model_mem[idx];
        end else begin
            exp_res = '0;
            for (int b = 0; b < 16; b++)
                if (rw[b]) model_mem[idx][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    // One accepted request; request fields are scrambled after accept.
    task automatic do_hit(input string nm, input logic [31:0] a, input logic [15:0] rw,
                          input logic [127:0] d, input bit drop, input logic [127:0] exp_res);
        int lat, n_rd, n_wr;
        logic [15:0]  wr_seen;
        logic [127:0] wd_seen, rd_seen;
        logic [AW-1:0] addr_seen;
        lat = -1; n_rd = 0; n_wr = 0; wr_seen = '0; wd_seen = '0; rd_seen = '0; addr_seen = '0;
        @(negedge clk);
        check({nm, "_ready"}, 128'(bus.res_ready_o), 128'(1));
        bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_data_i = d; bus.req_rw_i = rw;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.req_addr_i = $urandom;
                bus.req_data_i = {$urandom, $urandom, $urandom, $urandom};
                bus.req_rw_i   = 16'($urandom);
                if (drop) bus.req_valid_i = 1'b0;
            end
            if (bus.ram_rd_en_o) begin n_rd++; addr_seen = bus.ram_addr_o; end
            if (bus.ram_wr_en_o != '0) begin
                n_wr++; wr_seen = bus.ram_wr_en_o; wd_seen = bus.ram_wdata_o; addr_seen = bus.ram_addr_o;
            end
            if (bus.res_valid_o) begin
                lat = k; rd_seen = bus.res_data_o; bus.req_valid_i = 1'b0;
            end
        end
        check({nm, "_latency"}, 128'(lat), 128'(16));
        check({nm, "_rd_pulses"}, 128'(n_rd), 128'((rw == 16'h0) ? 1 : 0));
        check({nm, "_wr_pulses"}, 128'(n_wr), 128'((rw == 16'h0) ? 0 : 1));
        check({nm, "_ram_addr"}, 128'(addr_seen), 128'(model_idx(a)));
        if (rw != 16'h0) begin
            check({nm, "_wr_en"}, 128'(wr_seen), 128'(rw));
            check({nm, "_wdata"}, wd_seen, d);
        end
        check({nm, "_res_data"}, rd_seen, exp_res);
        @(negedge clk);
        check({nm, "_hold_data"}, bus.res_data_o, exp_res);
        check({nm, "_valid_low"}, 128'(bus.res_valid_o), 128'(0));
    endtask

    task automatic run_miss(input string nm, input logic [31:0] a);
        int bad;
        bad = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_rw_i = 16'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus.res_ready_o || bus.ram_rd_en_o || bus.ram_wr_en_o != '0 || bus.res_valid_o) bad++;
        end
        bus.req_valid_i = 1'b0;
        check({nm, "_quiet_cycles_bad"}, 128'(bad), 128'(0));
    endtask

    typedef struct {
        logic [31:0]  addr;
        logic [15:0]  rw;
        logic [127:0] data;
        bit           exp_hit;
        logic [127:0] exp_res;
    } vec_t;
    vec_t vecs[9];

    initial begin
        logic [127:0] exp_res, d;
        logic [31:0]  a;
        logic [15:0]  rw;
        int r1, r2, bad, nrd;
        logic [127:0] d1, d2;

        vecs[0] = '{32'h8000_0010, 16'h0000, 128'h0, 1'b1, {16{8'hA5}}};
        vecs[1] = '{32'h8000_0020, 16'h000F, 128'h1234, 1'b1, 128'h0};
        vecs[2] = '{32'h8000_0020, 16'h0000, 128'h0, 1'b1,
                    {32'hC0DE_0002, 32'hC0DE_0002, 32'hC0DE_0002, 32'h0000_1234}};
        vecs[3] = '{32'h3000_0000, 16'h0000, 128'h0, 1'b0, 128'h0};
        vecs[4] = '{32'h8000_0030, 16'hF000, {32'hDEAD_BEEF, 96'h0}, 1'b1, 128'h0};
        vecs[5] = '{32'h8000_0038, 16'h0000, 128'h0, 1'b1,
                    {32'hDEAD_BEEF, 32'hC0DE_0003, 32'hC0DE_0003, 32'hC0DE_0003}};
        vecs[6] = '{32'h800F_FFF0, 16'h0000, 128'h0, 1'b1, {4{32'hC0DE_1FFF}}};
        vecs[7] = '{32'h8010_0000, 16'h0000, 128'h0, 1'b0, 128'h0};
        vecs[8] = '{32'h0000_0010, 16'h0000, 128'h0, 1'b0, 128'h0};

        bus.req_valid_i = 1'b0;  bus.req_addr_i = '0;  bus.req_data_i = '0;  bus.req_rw_i = '0;
        bus2.req_valid_i = 1'b0; bus2.req_addr_i = '0; bus2.req_data_i = '0; bus2.req_rw_i = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = init_line(i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_init = 1'b0;
        check("rst_res_valid", 128'(bus.res_valid_o), 128'(0));
        check("rst_res_ready", 128'(bus.res_ready_o), 128'(1));
        check("rst_res_data",  bus.res_data_o, 128'h0);
        check("rst_rd_en",     128'(bus.ram_rd_en_o), 128'(0));
        check("rst_wr_en",     128'(bus.ram_wr_en_o), 128'(0));
        check("rst_ram_addr",  128'(bus.ram_addr_o), 128'(0));
        check("rst_wdata",     bus.ram_wdata_o, 128'h0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].exp_hit) begin
                model_txn(vecs[i].addr, vecs[i].rw, vecs[i].data, exp_res);
                do_hit($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rw, vecs[i].data, 1'b0, vecs[i].exp_res);
            end else begin
                run_miss($sformatf("vec%0d", i), vecs[i].addr);
            end
        end

        for (int i = 0; i < 24; i++) begin
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom)
               : (BASE | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15)));
            rw = ($urandom_range(0, 1) == 1) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
            d  = {$urandom, $urandom, $urandom, $urandom};
            if (model_hit(a)) begin
                model_txn(a, rw, d, exp_res);
                do_hit($sformatf("rnd%0d", i), a, rw, d, 1'($urandom_range(0, 1)), exp_res);
            end else begin
                run_miss($sformatf("rnd%0d", i), a);
            end
        end

        // Back-to-back reads of lines 3 and 4, second presented right after the first response.
        r1 = -1; r2 = -1; d1 = '0; d2 = '0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h8000_0030; bus.req_rw_i = 16'h0;
        for (int k = 1; k <= 80 && r2 < 0; k++) begin
            @(negedge clk);
            if (bus.res_valid_o) begin
                if (r1 < 0) begin
                    r1 = k; d1 = bus.res_data_o; bus.req_addr_i = 32'h8000_0040;
                end else begin
                    r2 = k; d2 = bus.res_data_o; bus.req_valid_i = 1'b0;
                end
            end
        end
        check("b2b_first_latency",  128'(r1), 128'(16));
        check("b2b_second_latency", 128'(r2), 128'(33));
        check("b2b_first_data",  d1, model_mem[3]);
        check("b2b_second_data", d2, model_mem[4]);

        // Reset five cycles into a read drops it silently.
        bad = 0;
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h8000_0010; bus.req_rw_i = 16'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (bus.res_valid_o) bad++;
        end
        rst = 1'b1; bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ready", 128'(bus.res_ready_o), 128'(1));
        check("mid_rst_valid", 128'(bus.res_valid_o), 128'(0));
        check("mid_rst_data",  bus.res_data_o, 128'h0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.res_valid_o || bus.ram_rd_en_o) bad++;
        end
        check("mid_rst_no_response", 128'(bad), 128'(0));
        do_hit("post_rst", 32'h8000_0010, 16'h0, 128'h0, 1'b0, model_mem[1]);

        // Minimum-delay build: read line 7.
        r1 = -1; nrd = 0; d1 = '0;
        @(negedge clk);
        check("d2_ready", 128'(bus2.res_ready_o), 128'(1));
        bus2.req_valid_i = 1'b1; bus2.req_addr_i = 32'h8000_0070; bus2.req_rw_i = 16'h0;
        for (int k = 1; k <= 10 && r1 < 0; k++) begin
            @(negedge clk);
            if (bus2.ram_rd_en_o) nrd++;
            if (bus2.res_valid_o) begin r1 = k; d1 = bus2.res_data_o; bus2.req_valid_i = 1'b0; end
        end
        check("d2_latency",   128'(r1), 128'(2));
        check("d2_rd_pulses", 128'(nrd), 128'(1));
        check("d2_data",      d1, model_mem[7]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_ram_ctrl.md
IOMEM_RAM_CTRL -- requirements
Module: iomem_ram_ctrl

Interface
REQ-001 SHALL have parameter RAM_DELAY, default 16, meaning cycles from request accept to response (legal range 2..255).
REQ-002 SHALL have parameter RAM_DEPTH, default 8192, meaning 128-bit RAM lines.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning RAM window base.
REQ-004 SHALL have parameter MASK_ADDR, default 32'h000F_FFFF, meaning RAM window offset mask.
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port req_valid_i, input, 1, bus request valid, held until response.
REQ-008 SHALL have port req_addr_i, input, 32, byte address.
REQ-009 SHALL have port req_data_i, input, 128, write line.
REQ-010 SHALL have port req_rw_i, input, 16, byte write strobes; all-zero = read.
REQ-011 SHALL have port res_valid_o, output, 1, one-cycle response pulse.
REQ-012 SHALL have port res_ready_o, output, 1, controller idle and able to accept.
REQ-013 SHALL have port res_data_o, output, 128, read line.
REQ-014 SHALL have port ram_addr_o, output, $clog2(RAM_DEPTH), line index = addr[$clog2(RAM_DEPTH)+3:4].
REQ-015 SHALL have port ram_wdata_o, output, 128, write line to RAM.
REQ-016 SHALL have port ram_wr_en_o, output, 16, byte enables to RAM.
REQ-017 SHALL have port ram_rd_en_o, output, 1, RAM read strobe.
REQ-018 SHALL have port ram_rdata_i, input, 128, RAM read data, valid one cycle after ram_rd_en_o.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-020 SHALL define hit = req_valid_i & ((req_addr_i & ~MASK_ADDR) == BASE_ADDR); misses are never accepted and never answered.
REQ-021 IDLE: on hit, latch addr/data/rw into request registers, go to ISSUE; res_ready_o = 1 only in IDLE.
REQ-022 ISSUE (1 cycle): drive ram_addr_o from latched addr; read -> ram_rd_en_o=1; write -> ram_wr_en_o=latched rw, ram_wdata_o=latched data; load down-counter with RAM_DELAY-2; go to WAIT.
REQ-023 ram_rd_en_o and ram_wr_en_o SHALL be nonzero only in ISSUE, for exactly one cycle per request.
REQ-024 Cycle after ISSUE of a read: capture ram_rdata_i into line buffer; writes capture 128'h0.
REQ-025 WAIT: decrement counter each cycle; at zero go to RESP.
REQ-026 RESP (1 cycle): res_valid_o=1, res_data_o=line buffer; next state IDLE.
REQ-027 Latency: accept at edge N -> res_valid_o high in cycle N+RAM_DELAY; RAM_DELAY=2 bypasses WAIT (ISSUE->RESP).
REQ-028 Back-to-back: new hit sampled in IDLE the cycle after RESP SHALL be accepted without a bubble.
REQ-029 req_addr_i/req_data_i/req_rw_i changes after accept SHALL be ignored; latched values used.
REQ-030 req_valid_i deassert mid-transaction SHALL NOT abort; RAM access and response still complete.
REQ-031 res_data_o SHALL hold the last line-buffer value outside RESP.

Reset
REQ-032 rst_i high at an edge SHALL force IDLE, counter 0, line buffer 0, request registers 0.
REQ-033 Outputs after reset: res_valid_o=0, res_ready_o=1, res_data_o=0, ram_rd_en_o=0, ram_wr_en_o=0, ram_addr_o=0, ram_wdata_o=0.
REQ-034 Reset mid-transaction SHALL drop the transaction with no response; a RAM write already issued in ISSUE is not undone.

Structure
REQ-035 State enum, line width (128), strobe width (16) and window constants SHALL live in ceres_param.
REQ-036 SHALL be a single module; no sub-module.

Verification
REQ-037 Read 0x8000_0010, RAM line 1 = 128'hA5..A5 -> ram_rd_en_o one cycle with ram_addr_o=1; res_valid_o 16 cycles after accept, res_data_o=128'hA5..A5.
REQ-038 Write 0x8000_0020, rw=16'h000F, data=128'h1234 -> ram_wr_en_o=16'h000F for one cycle, ram_addr_o=2; res_valid_o at +16, res_data_o=0.
REQ-039 Request at 0x3000_0000 -> res_ready_o stays 1, no RAM strobes, no res_valid_o for 40 cycles.
REQ-040 Two reads back-to-back (lines 3, 4) -> responses at +16 and +33 cycles from first accept, data in order.
REQ-041 rst_i asserted 5 cycles after read accept -> no res_valid_o, res_ready_o=1 next cycle, next read completes normally.
REQ-042 RAM_DELAY=2 build, read line 7 -> res_valid_o exactly 2 cycles after accept with line 7 data.
